fp_cmp_seq: RTL and testbench

//  Sequencer around the FPU compare datapath for FEQ/FLT/FLE/FMIN/FMAX, SP and DP.

---
 rtl/fp_cmp_seq.sv | 193 +++++++++++++++++++
 tb/tb_fp_cmp_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fp_cmp_seq.sv
// Compare/min/max sequencer for the FPU: accepts one FEQ/FLT/FLE/FMIN/FMAX op,
// evaluates it in one cycle from registered operands and holds the result until it is consumed.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready=1
// EVAL   | compare unit driven from captured operands, result registered
// RESP   | out_valid=1, result held until out_ready
module fp_cmp_seq #(
  parameter int              FLEN     = 64,
  parameter logic [FLEN-1:0] CANON_SP = 64'hFFFFFFFF7FC00000,
  parameter logic [FLEN-1:0] CANON_DP = 64'h7FF8000000000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_sp_dp,
  input  logic [FLEN-1:0] in_a,
  input  logic [FLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] out_result,
  output logic            out_nv
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  logic [1:0]      state;
  logic [2:0]      op_q;
  logic            sp_dp_q;
  logic [FLEN-1:0] a_q;
  logic [FLEN-1:0] b_q;
  logic [FLEN-1:0] result_q;
  logic            nv_q;

  logic            a_nan, b_nan, a_snan, b_snan;
  logic            sign_a, sign_b;
  logic [62:0]     mag_a, mag_b;
  logic            both_zero, eq, lt, le;
  logic            any_nan, any_snan;
  logic [FLEN-1:0] min_sel, max_sel, min_res, max_res;
  logic [FLEN-1:0] result_d;
  logic            nv_d;

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_RESP);
  assign out_result = result_q;
  assign out_nv     = nv_q;

  // Field extraction: SP looks only at the low word, upper bits are don't-care.
  always_comb begin
    if (sp_dp_q) begin
      a_nan  = (a_q[62:52] == 11'h7FF) && (a_q[51:0] != 52'd0);
      b_nan  = (b_q[62:52] == 11'h7FF) && (b_q[51:0] != 52'd0);
      a_snan = a_nan && !a_q[51];
      b_snan = b_nan && !b_q[51];
      sign_a = a_q[63];
      sign_b = b_q[63];
      mag_a  = a_q[62:0];
      mag_b  = b_q[62:0];
    end else begin
      a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
      a_snan = a_nan && !a_q[22];
      b_snan = b_nan && !b_q[22];
      sign_a = a_q[31];
      sign_b = b_q[31];
      mag_a  = {32'd0, a_q[30:0]};
      mag_b  = {32'd0, b_q[30:0]};
    end
  end

  always_comb begin
    any_nan   = a_nan || b_nan;
    any_snan  = a_snan || b_snan;
    both_zero = (mag_a == 63'd0) && (mag_b == 63'd0);
    eq        = both_zero || ((sign_a == sign_b) && (mag_a == mag_b));
    lt        = 1'b0;
    if (!both_zero) begin
      if (sign_a != sign_b)
        lt = sign_a;
      else if (!sign_a)
        lt = (mag_a < mag_b);
      else
        lt = (mag_a > mag_b);
    end
    le = lt || eq;
  end

  always_comb begin
    min_sel = lt ? a_q : b_q;
    max_sel = lt ? b_q : a_q;
    if (a_nan) begin
      min_sel = b_q;
      max_sel = b_q;
    end else if (b_nan) begin
      min_sel = a_q;
      max_sel = a_q;
    end else if (both_zero && (sign_a != sign_b)) begin
      min_sel = sign_a ? a_q : b_q;
      max_sel = sign_a ? b_q : a_q;
    end
    if (sp_dp_q) begin
      min_res = min_sel;
      max_res = max_sel;
    end else begin
      min_res = {32'hFFFFFFFF, min_sel[31:0]};
      max_res = {32'hFFFFFFFF, max_sel[31:0]};
    end
    if (a_nan && b_nan) begin
      min_res = sp_dp_q ? CANON_DP : CANON_SP;
      max_res = sp_dp_q ? CANON_DP : CANON_SP;
    end
  end

  always_comb begin
    result_d = '0;
    nv_d     = 1'b0;
    case (op_q)
      OP_FEQ: begin
        result_d = {{(FLEN-1){1'b0}}, eq && !any_nan};
        nv_d     = any_snan;
      end
      OP_FLT: begin
        result_d = {{(FLEN-1){1'b0}}, lt && !any_nan};
        nv_d     = any_nan;
      end
      OP_FLE: begin
        result_d = {{(FLEN-1){1'b0}}, le && !any_nan};
        nv_d     = any_nan;
      end
      OP_FMIN: begin
        result_d = min_res;
        nv_d     = any_snan;
      end
      OP_FMAX: begin
        result_d = max_res;
        nv_d     = any_snan;
      end
      default: begin
        result_d = '0;
        nv_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= 3'd0;
      sp_dp_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      nv_q     <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            sp_dp_q <= in_sp_dp;
            a_q     <= in_a;
            b_q     <= in_b;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          result_q <= result_d;
          nv_q     <= nv_d;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cmp_seq.sv
// Directed bench for fp_cmp_seq: hand-computed compare/min/max vectors, handshake
// timing, back-pressure, flush and mid-op reset.
module tb_fp_cmp_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_sp_dp;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_nv;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [2:0] FEQ = 3'd0, FLT = 3'd1, FLE = 3'd2, FMIN = 3'd3, FMAX = 3'd4;
  localparam logic SP = 1'b0, DP = 1'b1;

  fp_cmp_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_sp_dp   (in_sp_dp),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_nv     (out_nv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge and check it surfaces after exactly two edges.
  task automatic issue(input string tag, input logic [2:0] op, input logic sp_dp,
                       input logic [63:0] a, input logic [63:0] b);
    in_op    = op;
    in_sp_dp = sp_dp;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    chk({tag, " in_ready idle"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " out_valid eval"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " in_ready eval"}, {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk({tag, " out_valid resp"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic release_resp(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after ready"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " in_ready after ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic sp_dp,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic exp_nv);
    issue(tag, op, sp_dp, a, b);
    chk({tag, " result"}, out_result, exp_res);
    chk({tag, " nv"}, {63'd0, out_nv}, {63'd0, exp_nv});
    release_resp(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_sp_dp  = 1'b0;
    in_a      = 64'd0;
    in_b      = 64'd0;
    out_ready = 1'b0;
    #12;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_result", out_result, 64'd0);
    chk("reset out_nv", {63'd0, out_nv}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op_check("sp flt -1<1", FLT, SP, 64'h00000000BF800000, 64'h000000003F800000, 64'd1, 1'b0);
    op_check("sp flt hi ignored", FLT, SP, 64'hDEADBEEF3F800000, 64'h12345678BF800000, 64'd0, 1'b0);
    op_check("dp feq -0==+0", FEQ, DP, 64'h8000000000000000, 64'h0, 64'd1, 1'b0);
    op_check("sp feq snan", FEQ, SP, 64'h000000007F800001, 64'h000000003F800000, 64'd0, 1'b1);
    op_check("dp feq qnan quiet", FEQ, DP, 64'h7FF8000000000000, 64'h7FF8000000000000, 64'd0, 1'b0);
    op_check("sp feq inf", FEQ, SP, 64'h000000007F800000, 64'h000000007F800000, 64'd1, 1'b0);
    op_check("sp flt qnan nv", FLT, SP, 64'h000000007FC00000, 64'h0, 64'd0, 1'b1);
    op_check("dp fle equal", FLE, DP, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'd1, 1'b0);
    op_check("sp fmin zeros", FMIN, SP, 64'h0, 64'h0000000080000000, 64'hFFFFFFFF80000000, 1'b0);
    op_check("sp fmax zeros", FMAX, SP, 64'h0, 64'h0000000080000000, 64'hFFFFFFFF00000000, 1'b0);
    op_check("dp fmin 1,2", FMIN, DP, 64'h3FF0000000000000, 64'h4000000000000000, 64'h3FF0000000000000, 1'b0);
    op_check("dp fmax 1,2", FMAX, DP, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 1'b0);
    op_check("dp fmin -1,-2", FMIN, DP, 64'hBFF0000000000000, 64'hC000000000000000, 64'hC000000000000000, 1'b0);
    op_check("sp fmax qnan,2", FMAX, SP, 64'h000000007FC00000, 64'h0000000040000000, 64'hFFFFFFFF40000000, 1'b0);
    op_check("sp fmax both qnan", FMAX, SP, 64'h000000007FC00000, 64'h000000007FC00000, 64'hFFFFFFFF7FC00000, 1'b0);
    op_check("sp fmin snan,1", FMIN, SP, 64'h000000007F800001, 64'h000000003F800000, 64'hFFFFFFFF3F800000, 1'b1);
    op_check("dp fmax both nan", FMAX, DP, 64'h7FF8000000000000, 64'h7FF0000000000001, 64'h7FF8000000000000, 1'b1);
    op_check("reserved op", 3'd6, DP, 64'h3FF0000000000000, 64'h7FF0000000000001, 64'd0, 1'b0);

    // Back-pressure: result and flags hold while out_ready stays low.
    issue("dp fle qnan hold", FLE, DP, 64'h7FF8000000000000, 64'h3FF0000000000000);
    for (int i = 0; i < 5; i++) begin
      chk("hold out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold result", out_result, 64'd0);
      chk("hold nv", {63'd0, out_nv}, 64'd1);
      chk("hold in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    release_resp("dp fle qnan hold");

    // Produce a nonzero result so a flushed op visibly leaves it alone.
    op_check("dp fmax pre-flush", FMAX, DP, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 1'b0);
    in_op = FEQ; in_sp_dp = DP; in_a = 64'h0; in_b = 64'h0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush in eval state", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("flush no late valid", {63'd0, out_valid}, 64'd0);
    chk("flush result kept", out_result, 64'h4000000000000000);

    // Flush in RESP beats a simultaneous out_ready and drops the result.
    issue("flush resp", FLT, SP, 64'h00000000BF800000, 64'h000000003F800000);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush resp out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush resp in_ready", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset while a result is pending.
    issue("reset resp", FMAX, SP, 64'h0, 64'h0000000040000000);
    chk("reset resp result", out_result, 64'hFFFFFFFF40000000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("async rst result", out_result, 64'd0);
    chk("async rst in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_check("post reset sp fle", FLE, SP, 64'h000000003F800000, 64'h000000003F800000, 64'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
